lfsr_prng: RTL and testbench

- Pseudo-random index generator built from a Galois LFSR, optionally followed by a block-cipher scrambler.
- The cipher breaks the linearity of the shift register.
- Used by the butterfly TCDM interconnect to drive external arbitration priority (rr index); it advances only on cycles with a granted bank access.
- Output is a narrow slice of the scrambled state.

---
 rtl/lfsr_prng_pkg.sv | 31 +++
 rtl/lfsr_prng_cipher_layer.sv | 20 ++
 rtl/lfsr_prng.sv | 111 +++++++++++
 tb/tb_lfsr_prng.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/lfsr_prng_pkg.sv
// Shared constants and helpers for the LFSR PRNG: PRESENT sbox, Galois toggle masks
// and the 64-bit bit permutation used by each cipher round.
package lfsr_prng_pkg;

    // Entry n holds the sbox image of nibble value n (packed, so index 15 is listed first).
    localparam logic [15:0][3:0] SBOX = {
        4'h2, 4'h1, 4'h7, 4'h4, 4'h8, 4'hF, 4'hE, 4'h3,
        4'hD, 4'hA, 4'h0, 4'h9, 4'hB, 4'h6, 4'h5, 4'hC
    };

    // Maximal-length Galois toggle mask; zero flags an unsupported width.
    function automatic logic [63:0] get_mask(input int unsigned width);
        case (width)
            16:      return 64'h0000_0000_0000_B400;
            32:      return 64'h0000_0000_8020_0003;
            64:      return 64'hD800_0000_0000_0000;
            default: return 64'h0;
        endcase
    endfunction

    function automatic logic [63:0] perm64(input logic [63:0] d);
        logic [63:0] p;
        p = '0;
        for (int i = 0; i < 63; i++) begin
            p[(16 * i) % 63] = d[i];
        end
        p[63] = d[63];
        return p;
    endfunction

endpackage

// File: rtl/lfsr_prng_cipher_layer.sv
// One combinational scrambler round: PRESENT sbox on every nibble, then the bit permutation.
module lfsr_prng_cipher_layer
    import lfsr_prng_pkg::*;
(
    input  logic [63:0] data_i,
    output logic [63:0] data_o
);

    logic [63:0] sboxed;

    always_comb begin
        sboxed = '0;
        for (int n = 0; n < 16; n++) begin
            sboxed[n*4 +: 4] = SBOX[data_i[n*4 +: 4]];
        end
    end

    assign data_o = perm64(sboxed);

endmodule

// File: rtl/lfsr_prng.sv
// Galois LFSR index generator with an optional nonlinear scrambler on its output.
// Define LFSR_PRNG_SEED_LOAD_EN to add the ld_i/seed_i reseed ports.
module lfsr_prng
    import lfsr_prng_pkg::*;
#(
    parameter int unsigned          LfsrWidth    = 64,
    parameter int unsigned          OutWidth     = 8,
    parameter logic [LfsrWidth-1:0] RstVal       = '1,
    parameter int unsigned          CipherLayers = 0,
    parameter bit                   CipherReg    = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
`ifdef LFSR_PRNG_SEED_LOAD_EN
    input  logic                 ld_i,
    input  logic [LfsrWidth-1:0] seed_i,
`endif
    output logic [OutWidth-1:0]  out_o
);

    localparam logic [63:0]          MaskFull = get_mask(LfsrWidth);
    localparam logic [LfsrWidth-1:0] Mask     = MaskFull[LfsrWidth-1:0];

    if (LfsrWidth != 16 && LfsrWidth != 32 && LfsrWidth != 64) begin : g_err_width
        $error("lfsr_prng: LfsrWidth must be 16, 32 or 64");
    end
    if (OutWidth == 0 || OutWidth > LfsrWidth) begin : g_err_out
        $error("lfsr_prng: OutWidth must be in 1..LfsrWidth");
    end
    if (RstVal == '0) begin : g_err_rst
        $error("lfsr_prng: RstVal must be non-zero");
    end
    if (CipherLayers > 0 && LfsrWidth != 64) begin : g_err_cipher
        $error("lfsr_prng: the cipher needs LfsrWidth = 64");
    end

    logic [LfsrWidth-1:0] lfsr_q, lfsr_d;
    logic                 advance;

`ifdef LFSR_PRNG_SEED_LOAD_EN
    // A load wins over a step and freezes the cipher register for that cycle.
    assign advance = en_i & ~ld_i;

    always_comb begin
        lfsr_d = lfsr_q;
        if (ld_i) begin
            lfsr_d = (seed_i == '0) ? RstVal : seed_i;
        end else if (en_i) begin
            lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? Mask : '0);
        end
    end
`else
    assign advance = en_i;

    always_comb begin
        lfsr_d = lfsr_q;
        if (en_i) begin
            lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? Mask : '0);
        end
    end
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lfsr_q <= RstVal;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    if (CipherLayers == 0) begin : g_plain
        logic unused_advance;
        assign unused_advance = advance;
        assign out_o = lfsr_q[OutWidth-1:0];
    end else begin : g_cipher
        logic [CipherLayers:0][63:0] stage;
        logic [63:0]                 cipher_out;
        logic                        unused_cipher;

        assign stage[0] = 64'(lfsr_q);

        for (genvar l = 0; l < CipherLayers; l++) begin : g_layer
            lfsr_prng_cipher_layer u_layer (
                .data_i (stage[l]),
                .data_o (stage[l+1])
            );
        end

        assign cipher_out    = stage[CipherLayers];
        assign unused_cipher = ^cipher_out;

        if (CipherReg) begin : g_reg
            // Captures the scramble of the pre-step state, so it lags the LFSR by one step.
            logic [OutWidth-1:0] out_q;
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    out_q <= '0;
                end else if (advance) begin
                    out_q <= cipher_out[OutWidth-1:0];
                end
            end
            assign out_o = out_q;
        end else begin : g_comb
            logic unused_advance;
            assign unused_advance = advance;
            assign out_o = cipher_out[OutWidth-1:0];
        end
    end

endmodule

// File: tb/tb_lfsr_prng.sv
// Scoreboard bench for lfsr_prng: 16-bit plain, 64-bit plain and 64-bit 3-round registered cipher.
module tb_lfsr_prng;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en16 = 1'b0, en64 = 1'b0, enc = 1'b0;
    logic [15:0] out16;
    logic [63:0] out64;
    logic [5:0]  outc;
`ifdef LFSR_PRNG_SEED_LOAD_EN
    logic        ld16 = 1'b0;
    logic [15:0] seed16 = '0;
`endif

    always #5 clk = ~clk;

    lfsr_prng #(.LfsrWidth(16), .OutWidth(16), .CipherLayers(0)) u16 (
        .clk_i(clk), .rst_i(rst), .en_i(en16),
`ifdef LFSR_PRNG_SEED_LOAD_EN
        .ld_i(ld16), .seed_i(seed16),
`endif
        .out_o(out16));

    lfsr_prng #(.LfsrWidth(64), .OutWidth(64), .CipherLayers(0)) u64 (
        .clk_i(clk), .rst_i(rst), .en_i(en64),
`ifdef LFSR_PRNG_SEED_LOAD_EN
        .ld_i(1'b0), .seed_i(64'h0),
`endif
        .out_o(out64));

    lfsr_prng #(.LfsrWidth(64), .OutWidth(6), .CipherLayers(3), .CipherReg(1'b1)) uc (
        .clk_i(clk), .rst_i(rst), .en_i(enc),
`ifdef LFSR_PRNG_SEED_LOAD_EN
        .ld_i(1'b0), .seed_i(64'h0),
`endif
        .out_o(outc));

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] q16[$];
    logic [63:0] q64[$];
    logic [5:0]  qc[$];

    logic [15:0] m16;
    logic [63:0] m64, mc_state;
    logic [5:0]  mc_out;

    int sbox_t[16] = '{12, 5, 6, 11, 9, 0, 10, 13, 3, 14, 15, 8, 4, 7, 1, 2};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] galois(input logic [63:0] s, input int w);
        logic [63:0] mask;
        mask = (w == 16) ? 64'hB400 : 64'hD800_0000_0000_0000;
        return (s >> 1) ^ (s[0] ? mask : 64'h0);
    endfunction

    function automatic logic [63:0] cipher3(input logic [63:0] s);
        logic [63:0] x, y;
        x = s;
        for (int r = 0; r < 3; r++) begin
            for (int n = 0; n < 16; n++) x[n*4 +: 4] = 4'(sbox_t[x[n*4 +: 4]]);
            y = '0;
            for (int i = 0; i < 64; i++) y[(i == 63) ? 63 : (i * 16) % 63] = x[i];
            x = y;
        end
        return x;
    endfunction

    task automatic model_reset();
        m16 = 16'hFFFF; m64 = '1; mc_state = '1; mc_out = '0;
    endtask

    // Drive one cycle of enables and queue what each output must show after the next edge.
    task automatic issue(input bit e16, input bit e64, input bit ec);
        logic [63:0] c;
        @(negedge clk);
        en16 = e16; en64 = e64; enc = ec;
        if (e16) m16 = 16'(galois({48'h0, m16}, 16));
        if (e64) m64 = galois(m64, 64);
        if (ec) begin
            c = cipher3(mc_state);
            mc_out = c[5:0];
            mc_state = galois(mc_state, 64);
        end
        q16.push_back(m16); q64.push_back(m64); qc.push_back(mc_out);
    endtask

    task automatic async_reset();
        @(negedge clk);
        en16 = 0; en64 = 0; enc = 0;
        #1 rst = 1'b1;
        #1;
        check("async_rst_16", {48'h0, out16}, 64'hFFFF);
        check("async_rst_64", out64, '1);
        check("async_rst_c", {58'h0, outc}, 64'h0);
        #1 rst = 1'b0;
        model_reset();
    endtask

    initial begin : monitor
        forever begin
            @(posedge clk);
            #2;
            if (q16.size() > 0) check("sb_lfsr16", {48'h0, out16}, {48'h0, q16.pop_front()});
            if (q64.size() > 0) check("sb_lfsr64", out64, q64.pop_front());
            if (qc.size() > 0)  check("sb_cipher", {58'h0, outc}, {58'h0, qc.pop_front()});
        end
    end

    initial begin : stim
        int first_ret;
        bit zero_seen;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_16", {48'h0, out16}, 64'hFFFF);
        check("reset_64", out64, '1);
        check("reset_c", {58'h0, outc}, 64'h0);
        #1 rst = 1'b0;

        issue(1, 1, 1);
        @(posedge clk); #3;
        check("step1_16", {48'h0, out16}, 64'hCBFF);
        check("step1_64", out64, 64'hA7FF_FFFF_FFFF_FFFF);

        repeat (10) issue(0, 0, 0);
        for (int i = 0; i < 400; i++) begin
            if (i == 200) async_reset();
            issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        issue(0, 0, 0);
        repeat (3) @(posedge clk);
        #3;
        check("sb_drained", 64'(q16.size() + q64.size() + qc.size()), 64'h0);

`ifdef LFSR_PRNG_SEED_LOAD_EN
        async_reset();
        @(negedge clk);
        ld16 = 1; seed16 = 16'h1234; en16 = 1; m16 = 16'h1234; q16.push_back(m16);
        @(negedge clk);
        ld16 = 0; en16 = 1; m16 = 16'h091A; q16.push_back(m16);
        @(negedge clk);
        ld16 = 1; seed16 = 16'h0000; en16 = 1; m16 = 16'hFFFF; q16.push_back(m16);
        @(negedge clk);
        ld16 = 0; en16 = 0;
        repeat (2) @(posedge clk);
        #3;
        check("seed_drained", 64'(q16.size()), 64'h0);
`endif

        // Full period of the 16-bit register: first return to the reset value at step 65535.
        async_reset();
        first_ret = 0;
        zero_seen = 1'b0;
        @(negedge clk);
        en16 = 1;
        for (int i = 1; i <= 65535; i++) begin
            @(posedge clk);
            #2;
            if (out16 == 16'hFFFF && first_ret == 0) first_ret = i;
            if (out16 == 16'h0000) zero_seen = 1'b1;
        end
        en16 = 0;
        check("period16", 64'(first_ret), 64'd65535);
        check("never_zero", {63'h0, zero_seen}, 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
